pc_redirect_unit: RTL and testbench

Program-counter and branch-resolution block for the RV32I core; the consumer of the branch comparator. It drives the comparator's BrUn select and consumes the BrLT/BrEq flags. It decides taken/not-taken for conditional branches, computes JAL/JALR/branch targets, and owns the PC register. On a redirect it raises a registered one-cycle flush. Fetch uses static not-taken prediction, with sequential PC+4.

---
 rtl/pc_redirect_unit.sv | 75 +++++++
 tb/tb_pc_redirect_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: resolves branches/jumps in EX, owns the fetch PC and
// raises a registered one-cycle flush on redirect.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_is_jal,
    input  logic        ex_is_jalr,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_rs1,
    input  logic        BrLT,
    input  logic        BrEq,
    output logic        BrUn,
    output logic [31:0] pc,
    output logic        flush,
    output logic        trap_misaligned,
    output logic        trap_illegal_br,
    output logic [15:0] branch_cnt,
    output logic [15:0] taken_cnt
);
    logic        act;
    logic        sel_jalr;
    logic        sel_jal;
    logic        sel_br;
    logic        illegal;
    logic        cond;
    logic        taken;
    logic        redirect;
    logic        br_eval;
    logic        br_taken;
    logic [31:0] target;

    always_comb begin
        BrUn     = ex_is_branch & ex_funct3[1];
        act      = ex_valid & ~stall & ~flush;
        sel_jalr = ex_is_jalr;
        sel_jal  = ~ex_is_jalr & ex_is_jal;
        sel_br   = ~ex_is_jalr & ~ex_is_jal & ex_is_branch;
        illegal  = ex_funct3[2:1] == 2'b01;
        // funct3[0] inverts the sense; 010/011 never take
        cond     = ex_funct3[2] ? (BrLT ^ ex_funct3[0]) :
                   ex_funct3[1] ? 1'b0 : (BrEq ^ ex_funct3[0]);
        target   = sel_jalr ? ((ex_rs1 + ex_imm) & ~32'h1) : (ex_pc + ex_imm);
        taken    = act & (sel_jal | sel_jalr | (sel_br & cond));
        redirect = taken & ~target[1];
        br_eval  = act & sel_br;
        br_taken = br_eval & cond;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc              <= RESET_PC;
            flush           <= 1'b0;
            trap_misaligned <= 1'b0;
            trap_illegal_br <= 1'b0;
            branch_cnt      <= 16'h0;
            taken_cnt       <= 16'h0;
        end else begin
            pc              <= redirect ? target : stall ? pc : pc + 32'd4;
            flush           <= redirect;
            trap_misaligned <= taken & target[1];
            trap_illegal_br <= br_eval & illegal;
            if (br_eval && branch_cnt != 16'hFFFF)
                branch_cnt <= branch_cnt + 16'd1;
            if (br_taken && taken_cnt != 16'hFFFF)
                taken_cnt <= taken_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed vectors; expectations queued per cycle and
// compared by an independent monitor just after each rising edge.
module tb_pc_redirect_unit;
    logic        clk = 1'b0;
    logic        reset, stall, ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc, ex_imm, ex_rs1;
    logic        BrLT, BrEq;
    logic        BrUn;
    logic [31:0] pc;
    logic        flush, trap_misaligned, trap_illegal_br;
    logic [15:0] branch_cnt, taken_cnt;

    pc_redirect_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .ex_valid(ex_valid),
        .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
        .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
        .BrLT(BrLT), .BrEq(BrEq), .BrUn(BrUn), .pc(pc), .flush(flush),
        .trap_misaligned(trap_misaligned), .trap_illegal_br(trap_illegal_br),
        .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        flush, tm, ti, brun;
        logic [15:0] bc, tc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, want);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            cmp(nm, "pc", pc, e.pc);
            cmp(nm, "flush", {31'b0, flush}, {31'b0, e.flush});
            cmp(nm, "trap_misaligned", {31'b0, trap_misaligned}, {31'b0, e.tm});
            cmp(nm, "trap_illegal_br", {31'b0, trap_illegal_br}, {31'b0, e.ti});
            cmp(nm, "BrUn", {31'b0, BrUn}, {31'b0, e.brun});
            cmp(nm, "branch_cnt", {16'b0, branch_cnt}, {16'b0, e.bc});
            cmp(nm, "taken_cnt", {16'b0, taken_cnt}, {16'b0, e.tc});
        end
    end

    task automatic tick(input string nm, input logic [31:0] epc, input logic ef, input logic etm,
                        input logic eti, input logic ebu, input logic [15:0] ebc, input logic [15:0] etc_);
        exp_t e;
        e.pc = epc; e.flush = ef; e.tm = etm; e.ti = eti; e.brun = ebu; e.bc = ebc; e.tc = etc_;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    task automatic set_instr(input logic v, input logic br, input logic jal, input logic jalr,
                             input logic [2:0] f3, input logic [31:0] p, input logic [31:0] imm,
                             input logic [31:0] rs1);
        ex_valid = v; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
        ex_funct3 = f3; ex_pc = p; ex_imm = imm; ex_rs1 = rs1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; BrLT = 1'b0; BrEq = 1'b0;
        set_instr(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0);
        tick("rst0", 32'h0, 0, 0, 0, 0, 0, 0);
        tick("rst1", 32'h0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick("seq4", 32'h4, 0, 0, 0, 0, 0, 0);
        tick("seq8", 32'h8, 0, 0, 0, 0, 0, 0);
        // BEQ taken
        set_instr(1, 1, 0, 0, 3'b000, 32'h100, 32'h20, 32'h0); BrEq = 1'b1;
        tick("beq", 32'h120, 1, 0, 0, 0, 1, 1);
        ex_valid = 1'b0;
        tick("beq_after", 32'h124, 0, 0, 0, 0, 1, 1);
        // BLTU not taken, BGEU taken
        set_instr(1, 1, 0, 0, 3'b110, 32'h100, 32'h20, 32'h0); BrEq = 1'b0; BrLT = 1'b0;
        tick("bltu", 32'h128, 0, 0, 0, 1, 2, 1);
        ex_funct3 = 3'b111;
        tick("bgeu", 32'h120, 1, 0, 0, 1, 3, 2);
        ex_valid = 1'b0;
        tick("bgeu_after", 32'h124, 0, 0, 0, 1, 3, 2);
        // JALR misaligned then aligned
        set_instr(1, 0, 0, 1, 3'b000, 32'h0, 32'h0, 32'h1003);
        tick("jalr_mis", 32'h128, 0, 1, 0, 0, 3, 2);
        ex_rs1 = 32'h1001;
        tick("jalr_ok", 32'h1000, 1, 0, 0, 0, 3, 2);
        ex_valid = 1'b0;
        tick("jalr_after", 32'h1004, 0, 0, 0, 0, 3, 2);
        // class priority
        set_instr(1, 1, 1, 1, 3'b000, 32'h300, 32'h10, 32'h2000);
        tick("prio_jalr", 32'h2010, 1, 0, 0, 0, 3, 2);
        ex_valid = 1'b0;
        tick("prio_after", 32'h2014, 0, 0, 0, 0, 3, 2);
        set_instr(1, 1, 1, 0, 3'b010, 32'h400, 32'h8, 32'h0);
        tick("prio_jal", 32'h408, 1, 0, 0, 1, 3, 2);
        set_instr(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0);
        tick("prio_jal_after", 32'h40C, 0, 0, 0, 0, 3, 2);
        // stall suppresses, then flush cycle gates the same instruction
        set_instr(1, 1, 0, 0, 3'b000, 32'h100, 32'h20, 32'h0); BrEq = 1'b1; stall = 1'b1;
        tick("stall0", 32'h40C, 0, 0, 0, 0, 3, 2);
        tick("stall1", 32'h40C, 0, 0, 0, 0, 3, 2);
        stall = 1'b0;
        tick("unstall", 32'h120, 1, 0, 0, 0, 4, 3);
        tick("flush_gate", 32'h124, 0, 0, 0, 0, 4, 3);
        reset = 1'b1;
        tick("rst_mid", 32'h0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0; ex_valid = 1'b0;
        tick("after_rst", 32'h4, 0, 0, 0, 0, 0, 0);
        // illegal funct3
        set_instr(1, 1, 0, 0, 3'b010, 32'h100, 32'h20, 32'h0);
        tick("illegal", 32'h8, 0, 0, 1, 1, 1, 0);
        ex_valid = 1'b0;
        tick("illegal_clr", 32'hC, 0, 0, 0, 1, 1, 0);
        // PC wrap
        set_instr(1, 0, 1, 0, 3'b000, 32'hFFFF_FFF0, 32'hC, 32'h0);
        tick("jal_hi", 32'hFFFF_FFFC, 1, 0, 0, 0, 1, 0);
        ex_valid = 1'b0;
        tick("wrap", 32'h0, 0, 0, 0, 0, 1, 0);
        // saturation using taken branches to a misaligned target (no flush)
        set_instr(1, 1, 0, 0, 3'b000, 32'h0, 32'h2, 32'h0); BrEq = 1'b1;
        repeat (65535) @(negedge clk);
        tick("sat0", 32'h0004_0000, 0, 1, 0, 0, 16'hFFFF, 16'hFFFF);
        tick("sat1", 32'h0004_0004, 0, 1, 0, 0, 16'hFFFF, 16'hFFFF);
        ex_valid = 1'b0;
        tick("sat_clr", 32'h0004_0008, 0, 0, 0, 0, 16'hFFFF, 16'hFFFF);
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
